// File: rtl/syscall_unit.sv
// Console syscall helper: prints a signed decimal integer or a single byte over a
// valid/ready byte stream, or halts the CPU. Stalls the pipeline while it is busy.
module syscall_unit #(
  parameter int unsigned V0_PRINT_INT  = 1,
  parameter int unsigned V0_EXIT       = 10,
  parameter int unsigned V0_PRINT_CHAR = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        stall,
  output logic        halted,
  output logic        bad_code
);

  localparam int unsigned NDIG = 10;
  localparam int unsigned CW   = 4;

  typedef enum logic [2:0] {
    IDLE, CONV, EMIT_SIGN, EMIT_DIG, EMIT_CHAR, HALT
  } state_t;

  state_t          state, state_n;
  logic            syscall_q;
  logic [31:0]     mag, mag_n, mag_div;
  logic [CW-1:0]   mag_mod;
  logic            neg, neg_n;
  logic [CW-1:0]   cnt, cnt_n, idx, idx_n, idx_m1;
  logic [CW-1:0]   dig_buf [NDIG];
  logic            dig_we;
  logic [7:0]      tx_data_n;
  logic            tx_valid_n, halted_n, bad_n;
  logic            accept;

  assign accept  = (state == IDLE) && syscall && !syscall_q;
  assign stall   = (state != IDLE) || accept;
  assign mag_div = mag / 32'd10;
  assign mag_mod = CW'(mag % 32'd10);
  assign idx_m1  = idx - CW'(1);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      syscall_q <= 1'b0;
      mag       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      halted    <= 1'b0;
      bad_code  <= 1'b0;
      for (int i = 0; i < NDIG; i++) dig_buf[i] <= '0;
    end else begin
      state     <= state_n;
      syscall_q <= syscall;
      mag       <= mag_n;
      neg       <= neg_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      tx_data   <= tx_data_n;
      tx_valid  <= tx_valid_n;
      halted    <= halted_n;
      bad_code  <= bad_n;
      if (dig_we) dig_buf[cnt] <= mag_mod;
    end
  end

  // Next-state and next-output logic; tx_* are computed one cycle ahead
  always_comb begin
    state_n    = state;
    mag_n      = mag;
    neg_n      = neg;
    cnt_n      = cnt;
    idx_n      = idx;
    tx_data_n  = tx_data;
    tx_valid_n = 1'b0;
    halted_n   = halted;
    bad_n      = 1'b0;
    dig_we     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (v0 == 32'(V0_PRINT_CHAR)) begin
            state_n    = EMIT_CHAR;
            tx_data_n  = a0[7:0];
            tx_valid_n = 1'b1;
          end else if (v0 == 32'(V0_PRINT_INT)) begin
            state_n = CONV;
            neg_n   = a0[31];
            mag_n   = a0[31] ? (~a0 + 32'd1) : a0;
            cnt_n   = '0;
          end else if (v0 == 32'(V0_EXIT)) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end else begin
            bad_n = 1'b1;
          end
        end
      end
      CONV: begin
        dig_we = 1'b1;
        mag_n  = mag_div;
        cnt_n  = cnt + CW'(1);
        // The digit written on the final pass is the most significant one
        if (mag_div == 32'd0) begin
          idx_n      = cnt;
          tx_valid_n = 1'b1;
          if (neg) begin
            state_n   = EMIT_SIGN;
            tx_data_n = 8'h2D;
          end else begin
            state_n   = EMIT_DIG;
            tx_data_n = 8'h30 + {4'h0, mag_mod};
          end
        end
      end
      EMIT_SIGN: begin
        tx_valid_n = 1'b1;
        if (tx_ready) begin
          state_n   = EMIT_DIG;
          tx_data_n = 8'h30 + {4'h0, dig_buf[idx]};
        end
      end
      EMIT_DIG: begin
        tx_valid_n = 1'b1;
        if (tx_ready) begin
          if (idx == '0) begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
          end else begin
            idx_n     = idx_m1;
            tx_data_n = 8'h30 + {4'h0, dig_buf[idx_m1]};
          end
        end
      end
      EMIT_CHAR: begin
        tx_valid_n = 1'b1;
        if (tx_ready) begin
          state_n    = IDLE;
          tx_valid_n = 1'b0;
        end
      end
      HALT: begin
        halted_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
